prng_share_ctrl: RTL and testbench



---
 rtl/prng_share_pkg.sv | 8 +
 rtl/prng_share_ctrl_rr_arbiter.sv | 36 +++
 rtl/prng_share_ctrl.sv | 120 ++++++++++++
 tb/tb_prng_share_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/prng_share_pkg.sv
// prng_share_pkg: shared types and sizing helpers for the PRNG sharing controller.
package prng_share_pkg;
    typedef enum logic [1:0] {SEED_WAIT, LOAD, WARMUP, SERVE} state_t;
    localparam int SEED_W = 32;
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/prng_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter; pointer moves past the winner when advance is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_hit;
    int            w_j;
    always_comb begin
        gnt   = '0;
        w_idx = '0;
        w_hit = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(r_ptr) + k) % N;
            if (!w_hit && req[w_j]) begin
                w_hit      = 1'b1;
                gnt[w_j]   = 1'b1;
                w_idx      = PW'(w_j);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (advance && w_hit)
            r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + 1'b1;
    end
endmodule

// File: rtl/prng_share_ctrl.sv
// prng_share_ctrl: seeds, warms up and periodically reseeds a shared PRNG, serving words round-robin.
// Optional macro PRNG_SHARE_CTRL_HEALTH_EN adds a repetition test with a sticky health_err output.
module prng_share_ctrl
    import prng_share_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int RND_WIDTH       = 32,
    parameter int WARMUP_CYCLES   = 64,
    parameter int RESEED_INTERVAL = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_valid,
    input  logic [SEED_W-1:0]    seed_data,
    output logic                 seed_ready,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   rnd_valid,
    output logic [RND_WIDTH-1:0] rnd_data,
    output logic                 prng_enable,
    output logic                 prng_load,
    output logic [SEED_W-1:0]    prng_seed,
    input  logic [RND_WIDTH-1:0] prng_out,
    output logic                 ready,
    output logic                 reseed_req
`ifdef PRNG_SHARE_CTRL_HEALTH_EN
    ,
    output logic                 health_err
`endif
);
    localparam int WW = cnt_w(WARMUP_CYCLES);
    localparam int CW = cnt_w(RESEED_INTERVAL);
    state_t               r_state;
    logic [SEED_W-1:0]    r_seed;
    logic [WW-1:0]        r_warm;
    logic [CW-1:0]        r_words;
    logic [NUM_REQ-1:0]   r_rnd_valid;
    logic [RND_WIDTH-1:0] r_rnd_data;
    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic                 w_serve, w_grant, w_last_word, w_warm_done, w_health_trip;

    assign w_serve     = r_state == SERVE;
    assign gnt         = w_serve ? w_arb_gnt : '0;
    assign w_grant     = |gnt;
    assign w_last_word = r_words == CW'(RESEED_INTERVAL - 1);
    assign w_warm_done = r_warm == WW'(WARMUP_CYCLES - 1);
    assign seed_ready  = r_state == SEED_WAIT;
    assign reseed_req  = r_state == SEED_WAIT;
    assign prng_load   = r_state == LOAD;
    assign prng_seed   = r_seed;
    assign ready       = w_serve;
    assign prng_enable = (r_state == WARMUP) || w_grant;
    assign rnd_valid   = r_rnd_valid;
    assign rnd_data    = r_rnd_data;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (w_serve),
        .gnt     (w_arb_gnt)
    );

`ifdef PRNG_SHARE_CTRL_HEALTH_EN
    logic [RND_WIDTH-1:0] r_last;
    logic                 r_have, r_rep, w_same;
    // r_rep remembers that the previous served word already repeated its predecessor
    assign w_same        = r_have && (prng_out == r_last);
    assign w_health_trip = w_grant && w_same && r_rep;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last     <= '0;
            r_have     <= 1'b0;
            r_rep      <= 1'b0;
            health_err <= 1'b0;
        end else if (w_grant) begin
            r_last <= prng_out;
            r_have <= 1'b1;
            r_rep  <= w_same && !w_health_trip;
            if (w_health_trip)
                health_err <= 1'b1;
        end
    end
`else
    assign w_health_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= SEED_WAIT;
            r_seed      <= '0;
            r_warm      <= '0;
            r_words     <= '0;
            r_rnd_valid <= '0;
            r_rnd_data  <= '0;
        end else begin
            r_rnd_valid <= gnt;
            if (w_grant)
                r_rnd_data <= prng_out;
            case (r_state)
                SEED_WAIT: if (seed_valid) begin
                    r_seed  <= seed_data;
                    r_state <= LOAD;
                end
                LOAD: r_state <= WARMUP;
                WARMUP: begin
                    r_warm <= w_warm_done ? '0 : r_warm + 1'b1;
                    if (w_warm_done)
                        r_state <= SERVE;
                end
                SERVE: if (w_grant) begin
                    r_words <= w_last_word ? '0 : r_words + 1'b1;
                    if (w_last_word || w_health_trip)
                        r_state <= SEED_WAIT;
                end
                default: r_state <= SEED_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_prng_share_ctrl.sv
// tb_prng_share_ctrl: lockstep reference-model bench with directed phases and random traffic.
module tb_prng_share_ctrl;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int WC = 64;
    localparam int RI = 16;

    logic          clk = 1'b0, rst_n = 1'b0, seed_valid = 1'b0;
    logic [31:0]   seed_data = '0;
    logic          seed_ready, prng_enable, prng_load, ready, reseed_req;
    logic [N-1:0]  req = '0, gnt, rnd_valid;
    logic [W-1:0]  rnd_data, prng_out = '0;
    logic [31:0]   prng_seed;
`ifdef PRNG_SHARE_CTRL_HEALTH_EN
    logic          health_err;
`endif

    int n_tests = 0, n_fail = 0;
    bit            m_need = 1'b1, m_load = 1'b0;
    int            m_warm = 0, m_words = 0, m_ptr = 0;
    logic [N-1:0]  m_pend = '0;
    logic [W-1:0]  m_data = '0;
    logic [31:0]   m_seed = '0;
    int            last_gi;
    logic [N-1:0]  last_g;
    logic          last_en, last_load, last_reseed;
    logic [31:0]   last_seed;

    always #5 clk = ~clk;

    prng_share_ctrl #(
        .NUM_REQ(N), .RND_WIDTH(W), .WARMUP_CYCLES(WC), .RESEED_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(seed_ready), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
        .rnd_data(rnd_data), .prng_enable(prng_enable), .prng_load(prng_load),
        .prng_seed(prng_seed), .prng_out(prng_out), .ready(ready), .reseed_req(reseed_req)
`ifdef PRNG_SHARE_CTRL_HEALTH_EN
        , .health_err(health_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: new PRNG word, compare against the model, advance the model and the DUT.
    task automatic step();
        bit           srv;
        logic [N-1:0] eg;
        prng_out = $urandom;
        #1;
        srv     = !m_need && !m_load && m_warm == 0;
        eg      = '0;
        last_gi = -1;
        if (srv)
            for (int k = 0; k < N; k++)
                if (last_gi < 0 && req[(m_ptr + k) % N]) last_gi = (m_ptr + k) % N;
        if (last_gi >= 0) eg[last_gi] = 1'b1;
        last_g = gnt; last_en = prng_enable; last_load = prng_load;
        last_seed = prng_seed; last_reseed = reseed_req;
        chk("gnt", gnt, eg);
        chk("seed_ready", seed_ready, m_need);
        chk("reseed_req", reseed_req, m_need);
        chk("ready", ready, srv);
        chk("prng_load", prng_load, m_load);
        chk("prng_enable", prng_enable, m_warm > 0 || last_gi >= 0);
        chk("rnd_valid", rnd_valid, m_pend);
        chk("rnd_data", rnd_data, m_data);
        if (m_load) chk("prng_seed", prng_seed, m_seed);
        if (!rst_n) begin
            m_need = 1'b1; m_load = 1'b0; m_warm = 0; m_words = 0; m_ptr = 0;
            m_pend = '0; m_data = '0;
        end else begin
            m_pend = eg;
            if (last_gi >= 0) begin
                m_data = prng_out;
                m_ptr  = (last_gi + 1) % N;
                m_words++;
                if (m_words == RI) begin
                    m_words = 0;
                    m_need  = 1'b1;
                end
            end else if (m_need) begin
                if (seed_valid) begin
                    m_seed = seed_data; m_need = 1'b0; m_load = 1'b1;
                end
            end else if (m_load) begin
                m_load = 1'b0; m_warm = WC;
            end else if (m_warm > 0) begin
                m_warm--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic seed_and_warm(input logic [31:0] s);
        seed_data = s; seed_valid = 1'b1;
        step();
        seed_valid = 1'b0;
        for (int i = 0; i < 300 && !ready; i++) step();
        chk("ready_timeout", ready, 1'b1);
    endtask

    initial begin
        int en, cnt;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;
        // seed word 1: one load pulse, then exactly WC enable cycles before ready
        seed_data = 32'h0000_0001; seed_valid = 1'b1;
        step();
        seed_valid = 1'b0;
        step();
        chk("load_pulse", last_load, 1'b1);
        chk("load_seed", last_seed, 32'h1);
        en = 0;
        for (int i = 0; i < 300 && !ready; i++) begin
            step();
            en += int'(last_en);
        end
        chk("warm_cycles", en, WC);
        chk("ready_rise", ready, 1'b1);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rr_order", last_gi, i % N);
        end
        req = 4'b0100; en = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("solo_gnt", last_g, 4'b0100);
            en += int'(last_en);
        end
        chk("solo_en", en, 3);
        req = '0;
        step();
        chk("idle_en", last_en, 1'b0);
        // fresh counter: continuous requester until reseed
        rst_n = 1'b0; step(); rst_n = 1'b1;
        seed_and_warm($urandom);
        req = 4'b0001; cnt = 0;
        for (int i = 0; i < 40 && !reseed_req; i++) begin
            step();
            cnt += (last_gi >= 0) ? 1 : 0;
        end
        chk("reseed_words", cnt, RI);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_gnt_reseed", last_g, '0);
        end
        req = '0;
        // reset during warm-up with a seed offered while reset is low
        seed_data = $urandom; seed_valid = 1'b1;
        step();
        seed_valid = 1'b0;
        repeat (11) step();
        rst_n = 1'b0; seed_valid = 1'b1; seed_data = $urandom;
        step();
        step();
        chk("rst_warm_en", last_en, 1'b0);
        chk("rst_reseed", last_reseed, 1'b1);
        rst_n = 1'b1; seed_valid = 1'b0;
        step();
        chk("seed_ignored", seed_ready, 1'b1);
        // random traffic with occasional resets and reseeds
        for (int i = 0; i < 3000; i++) begin
            rst_n      = $urandom_range(0, 299) != 0;
            seed_valid = $urandom_range(0, 3) == 0;
            seed_data  = $urandom;
            req        = N'($urandom);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
